// File: rtl/axil_write_arbiter_if.sv
// ============================================================================
// Module   : axil_write_arbiter_if
// Brief    : AXI-Lite write channels (AW, W, B) shared by the write arbiter
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface axil_write_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  awready, wready, bresp, bvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output awready, wready, bresp, bvalid
  );
endinterface

`default_nettype wire

// File: rtl/axil_write_arbiter.sv
// ============================================================================
// Module   : axil_write_arbiter
// Brief    : Round-robin arbiter sharing one AXI-Lite write master port
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axil_write_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 256
) (
  input  wire logic                             clk,
  input  wire logic                             reset,
  input  wire logic [NUM_REQ-1:0]               i_req_valid,
  input  wire logic [NUM_REQ-1:0][ADDR_W-1:0]   i_req_addr,
  input  wire logic [NUM_REQ-1:0][DATA_W-1:0]   i_req_data,
  input  wire logic [NUM_REQ-1:0][DATA_W/8-1:0] i_req_strb,
  output logic      [NUM_REQ-1:0]               o_req_ready,
  output logic      [NUM_REQ-1:0]               o_rsp_valid,
  output logic      [1:0]                       o_rsp_resp,
  output logic                                  o_busy,
  axil_write_arbiter_if.master                  m_axil
);

  localparam int c_STRB_W = DATA_W / 8;
  localparam int c_IDX_W  = $clog2(NUM_REQ);
  localparam int c_CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               r_state,     w_state_nxt;
  logic [c_IDX_W-1:0]   r_last,      w_last_nxt;
  logic [c_IDX_W-1:0]   r_grant,     w_grant_nxt;
  logic [ADDR_W-1:0]    r_awaddr,    w_awaddr_nxt;
  logic [DATA_W-1:0]    r_wdata,     w_wdata_nxt;
  logic [c_STRB_W-1:0]  r_wstrb,     w_wstrb_nxt;
  logic                 r_awvalid,   w_awvalid_nxt;
  logic                 r_wvalid,    w_wvalid_nxt;
  logic                 r_bready,    w_bready_nxt;
  logic [NUM_REQ-1:0]   r_req_ready, w_req_ready_nxt;
  logic [NUM_REQ-1:0]   r_rsp_valid, w_rsp_valid_nxt;
  logic [1:0]           r_rsp_resp,  w_rsp_resp_nxt;
  logic                 r_busy;
  logic [c_CNT_W-1:0]   r_cnt,       w_cnt_nxt;

  logic                 w_found;
  logic [c_IDX_W-1:0]   w_grant_idx;
  logic                 w_aw_done;
  logic                 w_w_done;
  logic                 w_timeout;

  assign w_aw_done = !r_awvalid || m_axil.awready;
  assign w_w_done  = !r_wvalid  || m_axil.wready;
  assign w_timeout = (TIMEOUT != 0) && (r_cnt == c_CNT_W'(TIMEOUT - 1));

  // Search starts one past the last winner and wraps, giving rotating priority.
  always_comb begin
    w_found     = 1'b0;
    w_grant_idx = r_last;
    for (int k = 1; k <= NUM_REQ; k++) begin
      logic [c_IDX_W-1:0] v_idx;
      v_idx = c_IDX_W'((int'(r_last) + k) % NUM_REQ);
      if (!w_found && i_req_valid[v_idx]) begin
        w_found     = 1'b1;
        w_grant_idx = v_idx;
      end
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_last_nxt      = r_last;
    w_grant_nxt     = r_grant;
    w_awaddr_nxt    = r_awaddr;
    w_wdata_nxt     = r_wdata;
    w_wstrb_nxt     = r_wstrb;
    w_awvalid_nxt   = r_awvalid;
    w_wvalid_nxt    = r_wvalid;
    w_bready_nxt    = r_bready;
    w_req_ready_nxt = '0;
    w_rsp_valid_nxt = '0;
    w_rsp_resp_nxt  = r_rsp_resp;
    w_cnt_nxt       = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_awaddr_nxt    = i_req_addr[w_grant_idx];
          w_wdata_nxt     = i_req_data[w_grant_idx];
          w_wstrb_nxt     = i_req_strb[w_grant_idx];
          w_awvalid_nxt   = 1'b1;
          w_wvalid_nxt    = 1'b1;
          w_req_ready_nxt = NUM_REQ'(1) << w_grant_idx;
          w_last_nxt      = w_grant_idx;
          w_grant_nxt     = w_grant_idx;
          w_state_nxt     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // AW and W complete independently; the later one moves us on.
        w_awvalid_nxt = r_awvalid && !m_axil.awready;
        w_wvalid_nxt  = r_wvalid  && !m_axil.wready;
        if (w_aw_done && w_w_done) begin
          w_bready_nxt = 1'b1;
          w_cnt_nxt    = '0;
          w_state_nxt  = S_RESP;
        end
      end
      S_RESP: begin
        if (m_axil.bvalid && r_bready) begin
          w_rsp_resp_nxt  = m_axil.bresp;
          w_bready_nxt    = 1'b0;
          w_rsp_valid_nxt = NUM_REQ'(1) << r_grant;
          w_state_nxt     = S_DONE;
        end else if (w_timeout) begin
          w_rsp_resp_nxt  = 2'b10;
          w_bready_nxt    = 1'b0;
          w_rsp_valid_nxt = NUM_REQ'(1) << r_grant;
          w_state_nxt     = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt + c_CNT_W'(1);
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_last      <= c_IDX_W'(NUM_REQ - 1);
      r_grant     <= '0;
      r_awaddr    <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_req_ready <= '0;
      r_rsp_valid <= '0;
      r_rsp_resp  <= 2'b00;
      r_busy      <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_last      <= w_last_nxt;
      r_grant     <= w_grant_nxt;
      r_awaddr    <= w_awaddr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_wstrb     <= w_wstrb_nxt;
      r_awvalid   <= w_awvalid_nxt;
      r_wvalid    <= w_wvalid_nxt;
      r_bready    <= w_bready_nxt;
      r_req_ready <= w_req_ready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_resp  <= w_rsp_resp_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
      r_cnt       <= w_cnt_nxt;
    end
  end

  assign o_req_ready    = r_req_ready;
  assign o_rsp_valid    = r_rsp_valid;
  assign o_rsp_resp     = r_rsp_resp;
  assign o_busy         = r_busy;
  assign m_axil.awaddr  = r_awaddr;
  assign m_axil.awvalid = r_awvalid;
  assign m_axil.wdata   = r_wdata;
  assign m_axil.wstrb   = r_wstrb;
  assign m_axil.wvalid  = r_wvalid;
  assign m_axil.bready  = r_bready;

endmodule

`default_nettype wire
